// File: rtl/rv32im_id_ex_stage.sv
`default_nettype none
// ============================================================================
// rv32im_id_ex_stage : ID/EX pipeline register, load-use detection, operand forwarding
// Rev 1.0
// ============================================================================
module rv32im_id_ex_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic [2:0]  id_funct3,
  input  logic [6:0]  id_funct7,
  input  logic [1:0]  id_opcode,
  input  logic        id_use_imm,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_result,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_result,
  input  logic        ex_stall,
  input  logic        flush,
  output logic        id_stall,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic [31:0] ex_op1,
  output logic [31:0] ex_op2,
  output logic [31:0] ex_store_data,
  output logic [2:0]  ex_funct3,
  output logic [6:0]  ex_funct7,
  output logic [1:0]  ex_opcode
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [31:0] rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
  logic [31:0] imm_q, imm_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [6:0]  funct7_q, funct7_d;
  logic [1:0]  opcode_q, opcode_d;
  logic        use_imm_q, use_imm_d;
  logic        reg_write_q, reg_write_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;

  logic        w_hazard;
  logic        w_wb_en, w_mem_en;
  logic [31:0] w_fwd1, w_fwd2;

  assign w_wb_en  = wb_reg_write & (wb_rd != 5'd0);
  assign w_mem_en = mem_reg_write & (mem_rd != 5'd0);

  assign w_hazard = valid_q & mem_read_q & (rd_q != 5'd0) & id_valid &
                    ((id_rs1 == rd_q) | (id_rs2 == rd_q));
  assign id_stall = w_hazard | ex_stall;

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    imm_d       = imm_q;
    funct3_d    = funct3_q;
    funct7_d    = funct7_q;
    opcode_d    = opcode_q;
    use_imm_d   = use_imm_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    // A held instruction keeps its register-file reads coherent with retiring writes
    rs1_data_d  = (w_wb_en && wb_rd == rs1_q) ? wb_result : rs1_data_q;
    rs2_data_d  = (w_wb_en && wb_rd == rs2_q) ? wb_result : rs2_data_q;

    if (flush || (!ex_stall && w_hazard)) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end else if (!ex_stall) begin
      valid_d     = id_valid;
      pc_d        = id_pc;
      rs1_d       = id_rs1;
      rs2_d       = id_rs2;
      rd_d        = id_rd;
      imm_d       = id_imm;
      funct3_d    = id_funct3;
      funct7_d    = id_funct7;
      opcode_d    = id_opcode;
      use_imm_d   = id_use_imm;
      reg_write_d = id_reg_write & id_valid;
      mem_read_d  = id_mem_read & id_valid;
      mem_write_d = id_mem_write & id_valid;
      rs1_data_d  = (w_wb_en && wb_rd == id_rs1) ? wb_result : id_rs1_data;
      rs2_data_d  = (w_wb_en && wb_rd == id_rs2) ? wb_result : id_rs2_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q     <= 1'b0;
      pc_q        <= 32'd0;
      rs1_q       <= 5'd0;
      rs2_q       <= 5'd0;
      rd_q        <= 5'd0;
      rs1_data_q  <= 32'd0;
      rs2_data_q  <= 32'd0;
      imm_q       <= 32'd0;
      funct3_q    <= 3'd0;
      funct7_q    <= 7'd0;
      opcode_q    <= 2'd0;
      use_imm_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      funct3_q    <= funct3_d;
      funct7_q    <= funct7_d;
      opcode_q    <= opcode_d;
      use_imm_q   <= use_imm_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  // MEM is the younger producer, so it wins over WB
  assign w_fwd1 = (w_mem_en && mem_rd == rs1_q) ? mem_result :
                  (w_wb_en  && wb_rd  == rs1_q) ? wb_result  : rs1_data_q;
  assign w_fwd2 = (w_mem_en && mem_rd == rs2_q) ? mem_result :
                  (w_wb_en  && wb_rd  == rs2_q) ? wb_result  : rs2_data_q;

  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_op1        = w_fwd1;
  assign ex_op2        = use_imm_q ? imm_q : w_fwd2;
  assign ex_store_data = w_fwd2;
  assign ex_funct3     = funct3_q;
  assign ex_funct7     = funct7_q;
  assign ex_opcode     = opcode_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32im_id_ex_stage.sv
`default_nettype none
// ============================================================================
// tb_rv32im_id_ex_stage : directed self-checking bench for the ID/EX stage
// Rev 1.0
// ============================================================================
module tb_rv32im_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic [1:0]  id_opcode;
  logic        id_use_imm, id_reg_write, id_mem_read, id_mem_write;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic        ex_stall, flush;
  logic        id_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [31:0] ex_pc, ex_op1, ex_op2, ex_store_data;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  logic [1:0]  ex_opcode;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rv32im_id_ex_stage dut (
    .clk(clk), .reset_n(reset_n),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_funct3(id_funct3), .id_funct7(id_funct7), .id_opcode(id_opcode),
    .id_use_imm(id_use_imm), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .ex_stall(ex_stall), .flush(flush), .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_store_data(ex_store_data),
    .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_opcode(ex_opcode)
  );

  task automatic drive_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] imm, input logic ui,
                          input logic rw, input logic mr, input logic mw);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_use_imm = ui;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic bus_idle();
    mem_reg_write = 1'b0; mem_rd = 5'd0; mem_result = 32'd0;
    wb_reg_write = 1'b0; wb_rd = 5'd0; wb_result = 32'd0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ex_stall = 1'b0; flush = 1'b0;
    id_funct3 = 3'd0; id_funct7 = 7'd0; id_opcode = 2'd0;
    drive_id(1'b1, 32'h40, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 32'h7, 1'b0, 1'b1, 1'b1, 1'b1);
    bus_idle();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0h want 0", ex_valid); end
    n_checks++; if (ex_pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %0h want 0", ex_pc); end
    n_checks++; if (ex_op1 !== 32'd0 || ex_op2 !== 32'd0 || ex_store_data !== 32'd0) begin
      n_fail++; $display("FAIL reset_ops: got %0h %0h %0h want 0 0 0", ex_op1, ex_op2, ex_store_data); end
    n_checks++; if ({ex_reg_write, ex_mem_read, ex_mem_write} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000", {ex_reg_write, ex_mem_read, ex_mem_write}); end
    @(negedge clk);
    id_valid = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_load();
    @(negedge clk);
    drive_id(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 32'd5, 32'd9, 32'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    id_funct3 = 3'b010; id_funct7 = 7'h20; id_opcode = 2'b01;
    @(posedge clk); #1;
    n_checks++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL load_valid: got %0h want 1", ex_valid); end
    n_checks++; if (ex_op1 !== 32'd5) begin n_fail++; $display("FAIL load_op1: got %0h want 5", ex_op1); end
    n_checks++; if (ex_op2 !== 32'd7) begin n_fail++; $display("FAIL load_op2: got %0h want 7", ex_op2); end
    n_checks++; if (ex_opcode !== 2'b01) begin n_fail++; $display("FAIL load_opcode: got %0h want 1", ex_opcode); end
    n_checks++; if (ex_store_data !== 32'd9) begin n_fail++; $display("FAIL load_store: got %0h want 9", ex_store_data); end
    n_checks++; if (ex_pc !== 32'h100 || ex_rd !== 5'd3) begin
      n_fail++; $display("FAIL load_pc_rd: got %0h %0h want 100 3", ex_pc, ex_rd); end
    n_checks++; if (ex_funct3 !== 3'b010 || ex_funct7 !== 7'h20 || ex_reg_write !== 1'b1) begin
      n_fail++; $display("FAIL load_fields: got %0h %0h %0h want 2 20 1", ex_funct3, ex_funct7, ex_reg_write); end
    @(negedge clk);
    drive_id(1'b0, 32'h104, 5'd1, 5'd2, 5'd3, 32'd5, 32'd9, 32'd7, 1'b1, 1'b1, 1'b1, 1'b1);
    id_funct3 = 3'd0; id_funct7 = 7'd0; id_opcode = 2'd0;
    @(posedge clk); #1;
    n_checks++; if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write} !== 4'b0000) begin
      n_fail++; $display("FAIL load_invalid_ctrl: got %b want 0000", {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write}); end
    n_checks++; if (ex_pc !== 32'h104) begin n_fail++; $display("FAIL load_invalid_pc: got %0h want 104", ex_pc); end
  endtask

  task automatic test_forward();
    @(negedge clk);
    drive_id(1'b1, 32'h110, 5'd3, 5'd4, 5'd9, 32'd1, 32'h22, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    mem_reg_write = 1'b1; mem_rd = 5'd3; mem_result = 32'hA;
    wb_reg_write = 1'b1; wb_rd = 5'd3; wb_result = 32'hB;
    #1;
    n_checks++; if (ex_op1 !== 32'hA) begin n_fail++; $display("FAIL fwd_mem_wins: got %0h want a", ex_op1); end
    mem_reg_write = 1'b0;
    #1;
    n_checks++; if (ex_op1 !== 32'hB) begin n_fail++; $display("FAIL fwd_wb: got %0h want b", ex_op1); end
    wb_rd = 5'd4;
    #1;
    n_checks++; if (ex_op1 !== 32'd1) begin n_fail++; $display("FAIL fwd_none_rs1: got %0h want 1", ex_op1); end
    n_checks++; if (ex_store_data !== 32'hB || ex_op2 !== 32'hB) begin
      n_fail++; $display("FAIL fwd_rs2: got %0h %0h want b b", ex_store_data, ex_op2); end
    @(negedge clk);
    drive_id(1'b1, 32'h114, 5'd0, 5'd0, 5'd9, 32'h33, 32'h44, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    mem_reg_write = 1'b1; mem_rd = 5'd0; mem_result = 32'hA;
    wb_reg_write = 1'b1; wb_rd = 5'd0; wb_result = 32'hB;
    @(posedge clk); #1;
    n_checks++; if (ex_op1 !== 32'h33) begin n_fail++; $display("FAIL fwd_x0_op1: got %0h want 33", ex_op1); end
    n_checks++; if (ex_store_data !== 32'h44) begin n_fail++; $display("FAIL fwd_x0_store: got %0h want 44", ex_store_data); end
    bus_idle();
  endtask

  task automatic test_load_use();
    @(negedge clk);
    drive_id(1'b1, 32'h120, 5'd2, 5'd0, 5'd5, 32'h1000, 32'd0, 32'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    n_checks++; if (ex_mem_read !== 1'b1) begin n_fail++; $display("FAIL lu_lw_loaded: got %0h want 1", ex_mem_read); end
    @(negedge clk);
    drive_id(1'b1, 32'h124, 5'd6, 5'd5, 5'd8, 32'h10, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++; if (id_stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %0h want 1", id_stall); end
    @(posedge clk); #1;
    n_checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0) begin
      n_fail++; $display("FAIL lu_bubble: got %0h %0h %0h want 0 0 0", ex_valid, ex_reg_write, ex_mem_read); end
    n_checks++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_release: got %0h want 0", id_stall); end
    @(negedge clk);
    wb_reg_write = 1'b1; wb_rd = 5'd5; wb_result = 32'hDEAD;
    @(posedge clk); #1;
    bus_idle();
    #1;
    n_checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h124) begin
      n_fail++; $display("FAIL lu_add_loaded: got %0h %0h want 1 124", ex_valid, ex_pc); end
    n_checks++; if (ex_op1 !== 32'h10 || ex_op2 !== 32'hDEAD) begin
      n_fail++; $display("FAIL lu_add_ops: got %0h %0h want 10 dead", ex_op1, ex_op2); end
    @(negedge clk);
    drive_id(1'b1, 32'h128, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    drive_id(1'b1, 32'h12C, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL lu_rd_x0: got %0h want 0", id_stall); end
    ex_stall = 1'b1;
    #1;
    n_checks++; if (id_stall !== 1'b1) begin n_fail++; $display("FAIL stall_passthru: got %0h want 1", id_stall); end
    ex_stall = 1'b0;
  endtask

  task automatic test_stall_refresh();
    @(negedge clk);
    drive_id(1'b1, 32'h130, 5'd7, 5'd0, 5'd10, 32'h11, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive_id(1'b1, 32'h134, 5'd9, 5'd0, 5'd11, 32'h99, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    ex_stall = 1'b1;
    @(negedge clk);
    wb_reg_write = 1'b1; wb_rd = 5'd7; wb_result = 32'h55;
    @(negedge clk);
    bus_idle();
    @(negedge clk);
    ex_stall = 1'b0; id_valid = 1'b0;
    #1;
    n_checks++; if (ex_op1 !== 32'h55) begin n_fail++; $display("FAIL refresh_op1: got %0h want 55", ex_op1); end
    n_checks++; if (ex_pc !== 32'h130 || ex_valid !== 1'b1) begin
      n_fail++; $display("FAIL refresh_hold: got %0h %0h want 130 1", ex_pc, ex_valid); end
  endtask

  task automatic test_flush_stall();
    @(negedge clk);
    drive_id(1'b1, 32'h140, 5'd0, 5'd0, 5'd12, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    n_checks++; if (ex_mem_write !== 1'b1) begin n_fail++; $display("FAIL flush_pre: got %0h want 1", ex_mem_write); end
    @(negedge clk);
    ex_stall = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    n_checks++; if ({ex_valid, ex_reg_write, ex_mem_write} !== 3'b000) begin
      n_fail++; $display("FAIL flush_stall: got %b want 000", {ex_valid, ex_reg_write, ex_mem_write}); end
    @(negedge clk);
    ex_stall = 1'b0; flush = 1'b0;
    drive_id(1'b1, 32'h144, 5'd0, 5'd0, 5'd12, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_checks++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL flush_recover: got %0h want 1", ex_valid); end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin
      n_fail++; $display("FAIL flush_load: got %0h %0h want 0 0", ex_valid, ex_reg_write); end
    flush = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive_id(1'b1, 32'h150, 5'd3, 5'd0, 5'd13, 32'h77, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_checks++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre: got %0h want 1", ex_valid); end
    @(negedge clk);
    ex_stall = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (ex_valid !== 1'b0 || ex_pc !== 32'd0 || ex_rd !== 5'd0) begin
      n_fail++; $display("FAIL areset_regs: got %0h %0h %0h want 0 0 0", ex_valid, ex_pc, ex_rd); end
    n_checks++; if (ex_op1 !== 32'd0 || ex_reg_write !== 1'b0) begin
      n_fail++; $display("FAIL areset_ops: got %0h %0h want 0 0", ex_op1, ex_reg_write); end
    ex_stall = 1'b0;
    drive_id(1'b1, 32'h200, 5'd0, 5'd0, 5'd14, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL areset_held: got %0h want 0", ex_valid); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL areset_release: got %0h want 0", ex_valid); end
    @(posedge clk); #1;
    n_checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h200) begin
      n_fail++; $display("FAIL areset_first_load: got %0h %0h want 1 200", ex_valid, ex_pc); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_id(1'b1, 32'h300 + 32'(4 * i), 5'd0, 5'd0, 5'(i + 1), 32'd0, 32'd0, 32'(3 * i + 1),
               1'b1, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      n_checks++; if (ex_pc !== 32'h300 + 32'(4 * i) || ex_op2 !== 32'(3 * i + 1)) begin
        n_fail++; $display("FAIL b2b_%0d: got %0h %0h want %0h %0h", i, ex_pc, ex_op2,
                           32'h300 + 32'(4 * i), 32'(3 * i + 1)); end
    end
    @(negedge clk);
    id_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_forward();
    test_load_use();
    test_stall_refresh();
    test_flush_stall();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rv32im_id_ex_stage.md
RV32IM_ID_EX_STAGE -- requirements
Module: rv32im_id_ex_stage

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset; all state SHALL be rising-edge clocked.
REQ-002 clk  in  1  system clock.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 id_valid  in  1  decode slot holds an instruction.
REQ-005 id_pc, id_rs1_data, id_rs2_data, id_imm  in  32 each  decoded PC, register-file reads, sign-extended immediate.
REQ-006 id_rs1, id_rs2, id_rd  in  5 each  register indices.
REQ-007 id_funct3 in 3, id_funct7 in 7, id_opcode in 2  ALU control fields, passed through.
REQ-008 id_use_imm, id_reg_write, id_mem_read, id_mem_write  in  1 each  operand-select and write-back/memory controls.
REQ-009 mem_reg_write in 1, mem_rd in 5, mem_result in 32  EX/MEM forwarding source.
REQ-010 wb_reg_write in 1, wb_rd in 5, wb_result in 32  MEM/WB forwarding and register-file write source.
REQ-011 ex_stall  in  1  downstream busy; hold contents.
REQ-012 flush  in  1  taken branch/jump; kill contents.
REQ-013 id_stall  out  1  upstream must hold its instruction.
REQ-014 ex_valid out 1, ex_pc out 32, ex_rd out 5, ex_reg_write/ex_mem_read/ex_mem_write out 1 each  registered stage contents.
REQ-015 ex_op1, ex_op2, ex_store_data  out  32 each  forwarded ALU operands and store data.
REQ-016 ex_funct3 out 3, ex_funct7 out 7, ex_opcode out 2  registered ALU control.

Function
REQ-017 Internal registers SHALL hold valid, pc, rs1, rs2, rd, rs1_data, rs2_data, imm, funct3, funct7, opcode, use_imm, reg_write, mem_read, mem_write.
REQ-018 Load-use hazard SHALL be: ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (id_rs1==ex_rd | id_rs2==ex_rd).
REQ-019 id_stall SHALL be combinational: hazard | ex_stall.
REQ-020 Per-edge update priority SHALL be: flush > ex_stall > hazard > load.
REQ-021 flush SHALL clear valid, reg_write, mem_read, mem_write next edge, even during ex_stall.
REQ-022 ex_stall (no flush) SHALL hold all registers, except REQ-025 data refresh.
REQ-023 Hazard (no flush/stall) SHALL insert a bubble: valid, reg_write, mem_read, mem_write cleared; one-cycle penalty.
REQ-024 Load SHALL capture all id_* fields; valid = id_valid; when id_valid=0, control bits SHALL load as 0.
REQ-025 Register-file bypass: at load, if wb_reg_write & wb_rd!=0 & wb_rd==id_rsN, captured rsN_data SHALL be wb_result; while holding, if wb_reg_write & wb_rd!=0 & wb_rd==rsN, rsN_data SHALL update to wb_result.
REQ-026 Forwarded value fwdN SHALL be combinational: mem_result if mem_reg_write & mem_rd!=0 & mem_rd==rsN; else wb_result if wb_reg_write & wb_rd!=0 & wb_rd==rsN; else rsN_data. MEM SHALL win over WB.
REQ-027 Register x0 SHALL never be forwarded; ex_op1 = fwd1; ex_op2 = imm if use_imm else fwd2; ex_store_data = fwd2 always.
REQ-028 Latency SHALL be one cycle from id_* capture to ex_* outputs; throughput one instruction per cycle absent stalls.
REQ-029 Forwarding SHALL operate regardless of ex_valid; consumers gate on ex_valid.

Reset
REQ-030 reset_n low SHALL immediately clear every register to 0 regardless of clk; ex_op1/ex_op2/ex_store_data SHALL read 0 unless forwarded to a nonzero rs (rs=0 after reset, so 0).
REQ-031 Reset mid-stall or mid-bubble SHALL discard contents; first edge after release SHALL perform a normal load.

Verification
REQ-032 Load: id_valid=1, rs1_data=5, imm=7, use_imm=1, opcode=01 -> next cycle ex_valid=1, ex_op1=5, ex_op2=7, ex_opcode=01.
REQ-033 Forward priority: registered rs1=3, rs1_data=1; mem_rd=3 result=0xA, wb_rd=3 result=0xB, both write -> ex_op1=0xA; drop mem_reg_write -> 0xB; rs1=0 with mem_rd=0 -> ex_op1=rs1_data.
REQ-034 Load-use: ex holds lw x5, id has add rs2=x5 -> id_stall=1 one cycle, ex_valid=0 next edge, add captured the following edge with forwarded load data.
REQ-035 Stall refresh: ex_stall=1 for 3 cycles, wb writes x7=0x55 mid-stall, rs1=x7 -> after release ex_op1=0x55 with wb idle.
REQ-036 flush with ex_stall=1 -> next edge ex_valid=0, ex_reg_write=0, ex_mem_write=0.
REQ-037 Async reset asserted between edges -> all outputs 0 before next clk edge; ex_valid stays 0 until first load after release.
